// File: rtl/iir_sched_pkg.sv
// Shared types and defaults for the IIR channel scheduler.
package iir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } sched_state_e;

  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/iir_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant searching upward from ptr with wrap.
module iir_rr_arb #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any
);

  logic [CH_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((32'(ptr) + i) % NUM_CH);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/iir_ch_sched.sv
// Round-robin scheduler sharing one IIR engine between NUM_CH sources.
// Optional engine watchdog enabled by defining IIR_WDOG_EN.
module iir_ch_sched
  import iir_sched_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int DW      = DW_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*DW-1:0] req_data,
  output logic [NUM_CH-1:0]    req_ready,
  output logic                 eng_start,
  output logic [CH_W-1:0]      eng_ch,
  output logic [DW-1:0]        eng_x,
  input  logic                 eng_done,
  input  logic [DW-1:0]        eng_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [DW-1:0]        out_y,
  output logic                 out_err
);

  if (TIMEOUT < 1 || NUM_CH < 2) begin : g_param_check
    $error("iir_ch_sched: TIMEOUT must be >= 1 and NUM_CH >= 2");
  end

  sched_state_e    state_q, state_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [DW-1:0]   x_q, x_d;
  logic [DW-1:0]   y_q, y_d;

  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [DW-1:0]     x_sel;

  iir_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req     (req_valid),
    .ptr     (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    x_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) x_sel = req_data[i*DW +: DW];
    end
  end

`ifdef IIR_WDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef IIR_WDOG_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ch_d    = gnt_idx;
          x_d     = x_sel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef IIR_WDOG_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          y_d     = eng_y;
`ifdef IIR_WDOG_EN
          err_d   = 1'b0;
`endif
          state_d = DELIVER;
        end
`ifdef IIR_WDOG_EN
        // Abort on the TIMEOUT-th consecutive WAIT cycle without a result.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = DELIVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DELIVER: begin
        if (out_ready) begin
          rr_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

`ifdef IIR_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign eng_start = (state_q == ISSUE);
  assign eng_ch    = ch_q;
  assign eng_x     = x_q;
  assign out_valid = (state_q == DELIVER);
  assign out_ch    = ch_q;
  assign out_y     = y_q;

endmodule

// File: tb/tb_iir_ch_sched.sv
// Directed self-checking bench for iir_ch_sched; the bench drives the engine side itself.
module tb_iir_ch_sched;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int CH_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH*DW-1:0] req_data;
  logic [NUM_CH-1:0]    req_ready;
  logic                 eng_start;
  logic [CH_W-1:0]      eng_ch;
  logic [DW-1:0]        eng_x;
  logic                 eng_done;
  logic [DW-1:0]        eng_y;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH_W-1:0]      out_ch;
  logic [DW-1:0]        out_y;
  logic                 out_err;

  int checks = 0;
  int errors = 0;

  iir_ch_sched #(.NUM_CH(NUM_CH), .DW(DW), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .eng_start (eng_start),
    .eng_ch    (eng_ch),
    .eng_x     (eng_x),
    .eng_done  (eng_done),
    .eng_y     (eng_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_y     (out_y),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete job: grant expected now, engine answers lat cycles after eng_start.
  task automatic job(input int unsigned ch, input logic [7:0] x, input logic [7:0] y,
                     input int unsigned lat);
    logic [3:0] oh;
    oh = 4'(1 << ch);
    #1;
    chk("grant", 16'(req_ready), 16'(oh));
    tick();
    chk("start", 16'(eng_start), 16'h1);
    chk("eng_x", 16'(eng_x), 16'(x));
    chk("eng_ch", 16'(eng_ch), 16'(ch));
    chk("ready_busy", 16'(req_ready), 16'h0);
    tick();
    chk("start_pulse", 16'(eng_start), 16'h0);
    for (int unsigned i = 1; i < lat; i++) tick();
    eng_done = 1'b1;
    eng_y    = y;
    tick();
    eng_done = 1'b0;
    chk("out_valid", 16'(out_valid), 16'h1);
    chk("out_ch", 16'(out_ch), 16'(ch));
    chk("out_y", 16'(out_y), 16'(y));
    chk("out_err", 16'(out_err), 16'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_drop", 16'(out_valid), 16'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    eng_done  = 1'b0;
    eng_y     = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_ready", 16'(req_ready), 16'h0);
    chk("rst_start", 16'(eng_start), 16'h0);
    chk("rst_eng_ch", 16'(eng_ch), 16'h0);
    chk("rst_eng_x", 16'(eng_x), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_ch", 16'(out_ch), 16'h0);
    chk("rst_out_y", 16'(out_y), 16'h0);
    chk("rst_out_err", 16'(out_err), 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // All four valid: 10/20/30/40, grants 0,1,2,3,0
    req_data  = {8'd40, 8'd30, 8'd20, 8'd10};
    req_valid = 4'b1111;
    job(0, 8'h0A, 8'h01, 1);
    job(1, 8'h14, 8'h02, 2);
    job(2, 8'h1E, 8'h03, 1);
    job(3, 8'h28, 8'h04, 3);
    job(0, 8'h0A, 8'h05, 1);

    // Single channel 0, data 100, engine returns 37 after 3 cycles (pointer wraps to it)
    req_valid = 4'b0001;
    req_data  = {8'd0, 8'd0, 8'd0, 8'd100};
    job(0, 8'h64, 8'h25, 3);

    // Backpressure on channel 1
    req_valid = 4'b0010;
    req_data  = {8'd0, 8'd0, 8'h55, 8'd0};
    #1;
    chk("bp_grant", 16'(req_ready), 16'h2);
    tick();
    req_valid = 4'b0011;
    tick();
    eng_done = 1'b1;
    eng_y    = 8'h77;
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 16'(out_valid), 16'h1);
      chk("bp_y", 16'(out_y), 16'h77);
      chk("bp_ch", 16'(out_ch), 16'h1);
      chk("bp_ready", 16'(req_ready), 16'h0);
      chk("bp_start", 16'(eng_start), 16'h0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // Pointer now 2; only 0 and 1 valid -> wraps to 0
    #1;
    chk("bp_next_grant", 16'(req_ready), 16'h1);
    req_valid = 4'b0000;
    #1;
    chk("drop_no_grant", 16'(req_ready), 16'h0);

    // Spurious eng_done during ISSUE on channel 2
    req_valid = 4'b0100;
    req_data  = {8'd0, 8'h11, 8'd0, 8'd0};
    #1;
    chk("sp_grant", 16'(req_ready), 16'h4);
    tick();
    req_valid = 4'b0000;
    chk("sp_start", 16'(eng_start), 16'h1);
    eng_done = 1'b1;
    eng_y    = 8'h99;
    tick();
    eng_done = 1'b0;
    chk("sp_ignored", 16'(out_valid), 16'h0);
    tick();
    chk("sp_wait", 16'(out_valid), 16'h0);
    eng_done = 1'b1;
    eng_y    = 8'hCE;
    tick();
    eng_done = 1'b0;
    chk("sp_valid", 16'(out_valid), 16'h1);
    chk("sp_y", 16'(out_y), 16'h00CE);
    chk("sp_ch", 16'(out_ch), 16'h2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset asserted while waiting on channel 3
    req_valid = 4'b1000;
    req_data  = {8'h33, 8'd0, 8'd0, 8'd0};
    #1;
    chk("rw_grant", 16'(req_ready), 16'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("rw_eng_ch", 16'(eng_ch), 16'h3);
    rst_n = 1'b0;
    #1;
    chk("rw_eng_ch0", 16'(eng_ch), 16'h0);
    chk("rw_eng_x0", 16'(eng_x), 16'h0);
    chk("rw_start0", 16'(eng_start), 16'h0);
    chk("rw_valid0", 16'(out_valid), 16'h0);
    chk("rw_out_ch0", 16'(out_ch), 16'h0);
    chk("rw_out_y0", 16'(out_y), 16'h0);
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    req_data  = {8'd40, 8'd30, 8'd20, 8'd10};
    #1;
    chk("rw_first_grant", 16'(req_ready), 16'h1);
    chk("rw_no_output", 16'(out_valid), 16'h0);

`ifdef IIR_WDOG_EN
    // Engine never answers: abort after 8 WAIT cycles
    tick();
    req_valid = 4'b0000;
    chk("wd_start", 16'(eng_start), 16'h1);
    for (int i = 0; i < 8; i++) tick();
    chk("wd_not_yet", 16'(out_valid), 16'h0);
    tick();
    chk("wd_valid", 16'(out_valid), 16'h1);
    chk("wd_y", 16'(out_y), 16'h0);
    chk("wd_err", 16'(out_err), 16'h1);
    eng_done = 1'b1;
    eng_y    = 8'h42;
    out_ready = 1'b1;
    tick();
    eng_done  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wd_late_done", 16'(out_valid), 16'h0);
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
